// File: rtl/iq_demod_pkg.sv
// Shared types for the I/Q demodulator datapath: sample, I/Q pair and scheduler state.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package iq_demod_pkg;

    localparam int W = 5;

    typedef logic signed [W-1:0] sample_t;

    typedef struct packed {
        sample_t i;
        sample_t q;
    } iq_pair_t;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} sched_state_t;

endpackage

// File: rtl/iq_pair_fifo.sv
// Synchronous FIFO of I/Q pairs, DEPTH entries, wrap-bit binary pointers.
// Latency: a pair written at edge k is visible on rd_dat after edge k; pop is show-ahead.
// Backpressure: full is exported; caller must not push while full (same-cycle pop does not relieve full).
// Ports: clk/resetn; push + wr_dat write side; pop + rd_dat read side; full, empty, level status.
module iq_pair_fifo
    import iq_demod_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  iq_pair_t                 wr_dat,
    input  logic                     pop,
    output iq_pair_t                 rd_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    iq_pair_t       mem [DEPTH];
    logic [AW:0]    wptr;
    logic [AW:0]    rptr;

    // Extra MSB distinguishes full from empty when the index bits match.
    assign full   = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign empty  = (wptr == rptr);
    assign level  = wptr - rptr;
    assign rd_dat = mem[rptr[AW-1:0]];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
        end
    end

    // Storage needs no reset: contents are only read between the pointers.
    always_ff @(posedge clk) begin
        if (push) mem[wptr[AW-1:0]] <= wr_dat;
    end

endmodule

// File: rtl/iq_filter_sched.sv
// Buffers I/Q pairs, issues them to both channel filters on an ACTIVE-of-PERIOD cadence, re-pairs filter outputs.
// Latency: push -> f_in_valid >= 2 cycles (write edge, then pop edge); filter outputs -> m_valid 1 cycle.
// Backpressure: s_ready = !full of the input FIFO; no backpressure from the filters or the output side.
// Ports: clk/resetn; enable run request; s_valid/s_ready/s_i/s_q input pairs; f_in_valid/f_data_i/f_data_q
//        to filters; f_out_valid_i/_q, f_out_i/_q from filters; m_valid/m_i/m_q paired output;
//        sync_err sticky misalignment flag; drop_cnt and urun_cnt saturating counters.
module iq_filter_sched
    import iq_demod_pkg::*;
#(
    parameter int PERIOD = 5,
    parameter int ACTIVE = 4,
    parameter int DEPTH  = 4,
    parameter int CW     = 16
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                enable,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic signed [W-1:0] s_i,
    input  logic signed [W-1:0] s_q,
    output logic                f_in_valid,
    output logic signed [W-1:0] f_data_i,
    output logic signed [W-1:0] f_data_q,
    input  logic                f_out_valid_i,
    input  logic                f_out_valid_q,
    input  logic signed [W-1:0] f_out_i,
    input  logic signed [W-1:0] f_out_q,
    output logic                m_valid,
    output logic signed [W-1:0] m_i,
    output logic signed [W-1:0] m_q,
    output logic                sync_err,
    output logic [CW-1:0]       drop_cnt,
    output logic [CW-1:0]       urun_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int SW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [SW-1:0] SLOT_LAST = SW'(PERIOD - 1);
    localparam logic [SW:0]   ACT_LIM   = (SW + 1)'(ACTIVE);

    sched_state_t   state;
    logic [SW-1:0]  slot;
    logic [SW-1:0]  slot_inc;
    logic           active;
    logic           push;
    logic           pop;
    logic           full;
    logic           empty;
    logic           empty_after;
    logic [AW:0]    level;
    iq_pair_t       wr_dat;
    iq_pair_t       rd_dat;

    assign wr_dat.i = s_i;
    assign wr_dat.q = s_q;
    assign s_ready  = !full;
    assign push     = s_valid && !full;
    assign active   = ({1'b0, slot} < ACT_LIM);
    assign slot_inc = (slot == SLOT_LAST) ? '0 : slot + 1'b1;
    assign pop      = ((state == RUN) || (state == FLUSH)) && active && !empty;

    // FIFO occupancy after this edge is zero: nothing left and nothing arriving.
    assign empty_after = (empty && !push) || ((level == (AW + 1)'(1)) && pop && !push);

    iq_pair_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (push),
        .wr_dat (wr_dat),
        .pop    (pop),
        .rd_dat (rd_dat),
        .full   (full),
        .empty  (empty),
        .level  (level)
    );

    // Scheduler FSM together with the cadence counter, which is pinned to 0 whenever IDLE.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            slot  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    slot <= '0;
                    if (enable) state <= RUN;
                end
                RUN: begin
                    if (!enable && empty) begin
                        state <= IDLE;
                        slot  <= '0;
                    end else begin
                        if (!enable) state <= FLUSH;
                        slot <= slot_inc;
                    end
                end
                FLUSH: begin
                    if (enable) begin
                        state <= RUN;
                        slot  <= slot_inc;
                    end else if (empty_after) begin
                        state <= IDLE;
                        slot  <= '0;
                    end else begin
                        slot <= slot_inc;
                    end
                end
                default: begin
                    state <= IDLE;
                    slot  <= '0;
                end
            endcase
        end
    end

    // Issue register: data holds its last value between issues.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            f_in_valid <= 1'b0;
            f_data_i   <= '0;
            f_data_q   <= '0;
            urun_cnt   <= '0;
        end else begin
            f_in_valid <= pop;
            if (pop) begin
                f_data_i <= rd_dat.i;
                f_data_q <= rd_dat.q;
            end
            // Starvation only counts while running; a drain in FLUSH is expected to run dry.
            if ((state == RUN) && active && empty && (urun_cnt != '1))
                urun_cnt <= urun_cnt + 1'b1;
        end
    end

    // Output re-pairing: a lone valid from one filter is a misalignment and its sample is dropped.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_valid  <= 1'b0;
            m_i      <= '0;
            m_q      <= '0;
            sync_err <= 1'b0;
            drop_cnt <= '0;
        end else begin
            if (f_out_valid_i && f_out_valid_q) begin
                m_valid <= 1'b1;
                m_i     <= f_out_i;
                m_q     <= f_out_q;
            end else begin
                m_valid <= 1'b0;
                if (f_out_valid_i ^ f_out_valid_q) begin
                    sync_err <= 1'b1;
                    if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
                end
            end
        end
    end

endmodule
